// File: rtl/adder_operand_sequencer_if.sv
// rtl/adder_operand_sequencer_if.sv - operand word stream and result stream bundle for adder_operand_sequencer
//
// Signals:
//   in_valid/in_ready/in_data/carry_in : 32-bit operand word stream (A lo, A hi, B lo, B hi)
//   res_valid/res_ready/res_data/res_cout : 64-bit registered sum plus carry-out
// Modports:
//   master : producer of operand words and consumer of results
//   slave  : the sequencer itself
interface adder_operand_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        carry_in;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_cout;

    modport master (
        output in_valid, in_data, carry_in, res_ready,
        input  in_ready, res_valid, res_data, res_cout
    );

    modport slave (
        input  in_valid, in_data, carry_in, res_ready,
        output in_ready, res_valid, res_data, res_cout
    );
endinterface

// File: rtl/adder_operand_sequencer.sv
// rtl/adder_operand_sequencer.sv - collects two 64-bit operands, drives an external adder, returns the sum
//
// Ports:
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   flush           : synchronous abort, drops partial operands and any pending result
//   bus             : operand word stream in, result stream out (slave modport)
//   A, B, c0        : registered operands and carry-in to the external adder
//   sum_in, cout_in : external adder outputs, captured after ADD_WAIT cycles
//   busy            : high whenever not waiting for the first (A low) word
module adder_operand_sequencer #(
    parameter int ADD_WAIT  = 2,
    parameter bit CLEAR_OPS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    adder_operand_sequencer_if.slave  bus,
    output logic [63:0]               A,
    output logic [63:0]               B,
    output logic                      c0,
    input  logic [63:0]               sum_in,
    input  logic                      cout_in,
    output logic                      busy
);

    if (ADD_WAIT < 1 || ADD_WAIT > 15) begin : g_bad_add_wait
        $error("ADD_WAIT must be in 1..15");
    end

    localparam logic [3:0] WAIT_INIT = 4'(ADD_WAIT);

    typedef enum logic [2:0] {
        LD_AL = 3'd0,
        LD_AH = 3'd1,
        LD_BL = 3'd2,
        LD_BH = 3'd3,
        ADD   = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        rdy;
    logic        in_fire;
    logic        capture;
    logic        res_fire;
    logic [63:0] res_data_q;
    logic        res_cout_q;
    logic        res_valid_q;

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        capture   = 1'b0;
        res_fire  = 1'b0;
        case (state)
            LD_AL: begin rdy = 1'b1; if (bus.in_valid) state_nxt = LD_AH; end
            LD_AH: begin rdy = 1'b1; if (bus.in_valid) state_nxt = LD_BL; end
            LD_BL: begin rdy = 1'b1; if (bus.in_valid) state_nxt = LD_BH; end
            LD_BH: begin rdy = 1'b1; if (bus.in_valid) state_nxt = ADD;   end
            ADD: begin
                // Counter was loaded with ADD_WAIT on the last-word edge, so the
                // capture edge lands exactly ADD_WAIT cycles later.
                if (cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_fire  = 1'b1;
                    state_nxt = LD_AL;
                end
            end
            default: state_nxt = LD_AL;
        endcase
        // flush outranks every handshake in the same cycle
        if (flush) state_nxt = LD_AL;
    end

    assign in_fire = rdy && bus.in_valid && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LD_AL;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A           <= '0;
            B           <= '0;
            c0          <= 1'b0;
            cnt         <= '0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (flush) begin
            // result registers keep their last value; only the valid flag drops
            A           <= '0;
            B           <= '0;
            c0          <= 1'b0;
            cnt         <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (in_fire) begin
                case (state)
                    LD_AL: begin A[31:0]  <= bus.in_data; c0 <= bus.carry_in; end
                    LD_AH: A[63:32] <= bus.in_data;
                    LD_BL: B[31:0]  <= bus.in_data;
                    LD_BH: begin B[63:32] <= bus.in_data; cnt <= WAIT_INIT; end
                    default: ;
                endcase
            end
            if (state == ADD) cnt <= cnt - 4'd1;
            if (capture) begin
                res_data_q  <= sum_in;
                res_cout_q  <= cout_in;
                res_valid_q <= 1'b1;
            end
            if (res_fire) begin
                res_valid_q <= 1'b0;
                if (CLEAR_OPS) begin
                    A  <= '0;
                    B  <= '0;
                    c0 <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_cout  = res_cout_q;
    assign busy          = (state != LD_AL);

endmodule

// File: doc/adder_operand_sequencer.md
Name: adder_operand_sequencer

Overview:
- Upstream/downstream wrapper stage for the 64-bit ripple adder.
- Collects two 64-bit operands as four 32-bit words over a valid/ready stream: A low, A high, B low, B high.
- Drives the operands and carry-in to the external 64-bit adder, waits a programmable settle time, then registers the sum and carry-out.
- Presents the result on a valid/ready output stream.

Parameters:
- ADD_WAIT, 2, cycles allowed for the combinational adder to settle before capture; legal range 1..15.
- CLEAR_OPS, 1, when 1, the A/B operand registers are zeroed after each result handshake; when 0, they hold their last values.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; discards partial operands and any pending result.
- in_valid  input  1  in_data holds a valid word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  32  operand word.
- carry_in  input  1  carry-in, sampled with the A-low word.
- A  output  64  operand A to the adder.
- B  output  64  operand B to the adder.
- c0  output  1  registered carry-in to the adder.
- sum_in  input  64  adder sum (adder output1).
- cout_in  input  1  adder carry-out.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_data  output  64  registered sum.
- res_cout  output  1  registered carry-out.
- busy  output  1  high in any state other than LD_AL.

Behaviour:
- Reset (rst_n=0, asynchronous): state=LD_AL; A, B, c0, res_data, res_cout, res_valid and the wait counter all 0.
  - Combinational outputs follow from LD_AL: in_ready=1, busy=0.
  - Reset takes effect immediately, including mid-load, mid-ADD or during HOLD; no partial result survives.
- States: LD_AL -> LD_AH -> LD_BL -> LD_BH -> ADD -> HOLD -> LD_AL.
- in_ready is 1 in the four LD states and 0 in ADD and HOLD. A word is accepted only when in_valid&&in_ready at a clock edge.
- Word acceptance by state:
  - LD_AL: in_data goes to A[31:0] and carry_in to c0.
  - LD_AH: in_data goes to A[63:32].
  - LD_BL: in_data goes to B[31:0].
  - LD_BH: in_data goes to B[63:32]; the wait counter loads ADD_WAIT.
  - Each acceptance advances one state. With in_valid low the state holds indefinitely and registers are unchanged.
- ADD:
  - The counter decrements each cycle.
  - On the edge where the counter equals 1, sum_in goes to res_data, cout_in to res_cout, res_valid is set to 1, and the state moves to HOLD.
  - A, B and c0 are stable throughout ADD.
  - Latency: last-word accept edge to res_valid high is exactly ADD_WAIT cycles. With ADD_WAIT=1, res_valid rises one cycle after the B-high accept.
- HOLD:
  - res_valid=1 and res_data/res_cout are stable until the res_valid&&res_ready edge.
  - On that edge: res_valid goes to 0, the state goes to LD_AL, and if CLEAR_OPS=1 then A, B and c0 go to 0.
  - res_ready high outside HOLD has no effect.
- No overlap: a new operand set cannot begin loading until the result handshake completes. Max throughput is one result per ADD_WAIT+5 cycles, with 4 load cycles and 1 handshake cycle minimum.
- flush=1 at an edge, highest priority over all handshakes in the same cycle:
  - state goes to LD_AL and res_valid to 0;
  - A, B and c0 go to 0 regardless of CLEAR_OPS;
  - res_data and res_cout keep their values;
  - any word or result handshake in that same cycle is discarded (not counted as accepted).
- Arithmetic: the block does no addition itself. res_data/res_cout are exactly the adder outputs for the registered A, B, c0, i.e. a 65-bit result {res_cout,res_data}=A+B+c0 with wrap-around mod 2^64 on res_data.
- An ADD_WAIT value outside 1..15 is a configuration error. The counter is 4 bits wide.

Test Plan:
- Basic add: words 0xFFFFFFFF, 0x00000001, 0x00000001, 0x00000000 with carry_in=0 -> after ADD_WAIT cycles, res_data=0x0000000200000000, res_cout=0.
- Overflow: A=0xFFFFFFFFFFFFFFFF, B=0x0000000000000001, carry_in=0 -> res_data=0, res_cout=1. Repeat with B=0 and carry_in=1 -> same result.
- Input gaps and back-pressure:
  - in_valid toggled 1/0 each cycle -> exactly four words accepted, in order, and in_ready=0 during ADD/HOLD;
  - then hold res_ready=0 for 5 cycles -> res_valid and res_data stable, busy=1, in_ready=0;
  - raise res_ready -> one handshake, then LD_AL.
- Back-to-back operations: two operand sets with res_ready tied 1 and in_valid tied 1 -> results arrive ADD_WAIT+5 cycles apart; with CLEAR_OPS=1, A=B=0 in the cycle after each handshake.
- Flush: assert flush after 2 words accepted -> LD_AL and A=0. A fresh 4-word set then produces the correct sum, uncorrupted by the discarded words. Flush during HOLD drops res_valid and leaves res_data unchanged.
- Async reset: pull rst_n low mid-ADD between clock edges -> all registered outputs 0 immediately without waiting for clk. After release, the first accepted word lands in A[31:0].
